// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - two-requester round-robin arbiter driving a mux2x1 select
// Optional grant timeout enabled by defining MUX_SEL_TIMEOUT_EN.
module mux_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic done,
  output logic sel,
  output logic gnt0,
  output logic gnt1,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state;
  state_t     state_nxt;
  logic       last_sel;
  logic       sel_q;
  logic [3:0] hold_cnt;
  logic       timeout;

`ifdef MUX_SEL_TIMEOUT_EN
  assign timeout = (hold_cnt == HOLD_LAST);
`else
  assign timeout = 1'b0;
`endif

  // State register plus the round-robin flag, held select and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_sel <= 1'b1;
      sel_q    <= 1'b0;
      hold_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt == GRANT0 && state != GRANT0) begin
        last_sel <= 1'b0;
        sel_q    <= 1'b0;
      end else if (state_nxt == GRANT1 && state != GRANT1) begin
        last_sel <= 1'b1;
        sel_q    <= 1'b1;
      end
      if (state_nxt == IDLE || state_nxt != state) begin
        hold_cnt <= 4'd0;
      end else if (hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 4'd1;
      end
    end
  end

  // Every release passes through IDLE, so a grant never hands over directly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt = last_sel ? GRANT0 : GRANT1;
        end else if (req0) begin
          state_nxt = GRANT0;
        end else if (req1) begin
          state_nxt = GRANT1;
        end
      end
      GRANT0: begin
        if (done || !req0 || timeout) state_nxt = IDLE;
      end
      GRANT1: begin
        if (done || !req1 || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt0 = (state == GRANT0);
    gnt1 = (state == GRANT1);
    busy = (state == GRANT0) || (state == GRANT1);
    case (state)
      GRANT0:  sel = 1'b0;
      GRANT1:  sel = 1'b1;
      default: sel = sel_q;
    endcase
  end

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum cycles one requester keeps a grant (range 2..15; 4-bit counter).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req0  input  1  requester 0 wants mux input in0.
REQ-005 Port: req1  input  1  requester 1 wants mux input in1.
REQ-006 Port: done  input  1  current grant owner finished; sampled only while a grant is active.
REQ-007 Port: sel  output  1  registered select for downstream mux2x1; 0 = in0, 1 = in1.
REQ-008 Port: gnt0  output  1  registered grant to requester 0.
REQ-009 Port: gnt1  output  1  registered grant to requester 1.
REQ-010 Port: busy  output  1  high while any grant is active.

Function
REQ-011 States: IDLE, GRANT0, GRANT1; encoding is free, but no other state is reachable.
REQ-012 Outputs are decoded from state only: GRANT0 -> gnt0=1, sel=0, busy=1; GRANT1 -> gnt1=1, sel=1, busy=1; IDLE -> gnt0=gnt1=busy=0 and sel holds its last value.
REQ-013 gnt0 and gnt1 are never high in the same cycle.
REQ-014 IDLE transitions: req0 only -> GRANT0; req1 only -> GRANT1; neither -> stay IDLE.
REQ-015 IDLE with req0 and req1 both high: grant the requester not served last (round-robin flag last_sel).
REQ-016 Latency: a request sampled in IDLE produces a grant on the next rising edge (1 cycle).
REQ-017 last_sel updates on entry to GRANT0 (to 0) or GRANT1 (to 1).
REQ-018 GRANTx releases to IDLE when any of these holds: done=1, reqx=0, or timeout (REQ-026).
REQ-019 After a release, IDLE lasts exactly one cycle; re-arbitration then follows REQ-014/015.
REQ-020 Hold counter: cleared on entry to a grant state, incremented each cycle in a grant state, saturates at MAX_HOLD-1.
REQ-021 done while IDLE is ignored.
REQ-022 done and a new request on the other port in the same cycle: release first; the other port is granted after the IDLE cycle.

Reset
REQ-023 rst=1 at a clock edge forces: state=IDLE, sel=0, gnt0=0, gnt1=0, busy=0, hold counter=0.
REQ-024 last_sel resets to 1, so req0 wins the first simultaneous request.
REQ-025 rst asserted mid-grant drops the grant on that same edge; rst has priority over every other input.

Configuration
REQ-026 Macro MUX_SEL_TIMEOUT_EN defined: a grant releases to IDLE when the hold counter equals MAX_HOLD-1 and the owner is still requesting (grant length exactly MAX_HOLD cycles).
REQ-027 Macro MUX_SEL_TIMEOUT_EN undefined: no timeout; the grant is held until done=1 or reqx=0, and the hold counter is still present but has no effect on state.

Verification
REQ-028 rst=1 for 2 cycles, then req0=req1=0 -> sel=0, gnt0=gnt1=busy=0 on every cycle.
REQ-029 req0=1 from cycle 0, done pulse at cycle 3 -> gnt0=1 and sel=0 for cycles 1-3, IDLE at cycle 4, gnt0=1 again at cycle 5.
REQ-030 req0=req1=1 held, done pulsed every 3rd grant cycle -> grants alternate 0,1,0,1 with one IDLE cycle between them; sel toggles accordingly.
REQ-031 MUX_SEL_TIMEOUT_EN defined, MAX_HOLD=4, req1=1 held, done=0 -> gnt1 high 4 cycles, low 1 cycle, repeating.
REQ-032 MUX_SEL_TIMEOUT_EN undefined, same stimulus as REQ-031 -> gnt1 stays high for 20+ cycles.
REQ-033 rst=1 at grant cycle 2 of GRANT1 -> next cycle gnt1=0, sel=0, busy=0; with req0=req1=1 after rst deasserts, gnt0 is granted first.
